fifo_wr_arbiter: RTL

- Write-side scheduler for the async FIFO. Shares the single FIFO write port among NUM_REQ requesters in the clk_A domain.
- Arbitration is round-robin. Each grant is a burst of up to MAX_BURST beats.
- Honours the FIFO `full` flag directly, so the FIFO is never overflowed.
- Sits between client logic and the FIFO's wr_en/wr_data inputs.

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between requesting clients, the round-robin arbiter and the FIFO write port.
// master = arbiter side, slave = client/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          full;
    logic [NUM_REQ-1:0]            gnt;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          busy;
    logic [ID_WIDTH-1:0]           owner_id;

    modport master (
        input  req, req_data, full,
        output gnt, wr_en, wr_data, busy, owner_id
    );

    modport slave (
        output req, req_data, full,
        input  gnt, wr_en, wr_data, busy, owner_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst scheduler sharing one FIFO write port among NUM_REQ clk_A requesters.
// Optional FIFO_ARB_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic              clk_A,
    input  logic              rst_A,
`ifdef FIFO_ARB_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    fifo_wr_arbiter_if.master bus
);
    localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ);
    localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [ID_WIDTH-1:0]   owner;
    logic [ID_WIDTH-1:0]   owner_nx;
    logic [ID_WIDTH-1:0]   last_owner;
    logic [ID_WIDTH-1:0]   last_owner_nx;
    logic [ID_WIDTH-1:0]   sel;
    logic                  sel_vld;
    logic [CNT_WIDTH-1:0]  beat_cnt;
    logic [CNT_WIDTH-1:0]  beat_cnt_nx;
    logic                  own_req;
    logic                  acc;
    int unsigned           cand;
    logic [NUM_REQ-1:0]    gnt;
    logic [DATA_WIDTH-1:0] wr_data;

    // First pending requester above last_owner, wrapping, so the last owner comes last
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_owner) + k) % NUM_REQ;
            if (!sel_vld && bus.req[ID_WIDTH'(cand)]) begin
                sel     = ID_WIDTH'(cand);
                sel_vld = 1'b1;
            end
        end
    end

    assign own_req = bus.req[owner];
    assign acc     = (state == BURST) && own_req && !bus.full;

    always_ff @(posedge clk_A or posedge rst_A) begin
        if (rst_A) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_ID;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            beat_cnt   <= beat_cnt_nx;
        end
    end

    // Next state plus the same-cycle accept strobe and write mux
    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        beat_cnt_nx   = beat_cnt;
        gnt           = '0;
        wr_data       = '0;

        if (acc) gnt[owner] = 1'b1;
        if (state == BURST) wr_data = bus.req_data[32'(owner)*DATA_WIDTH +: DATA_WIDTH];

        unique case (state)
            IDLE: begin
                if (sel_vld && !bus.full) begin
                    state_nx    = BURST;
                    owner_nx    = sel;
                    beat_cnt_nx = '0;
                end
            end
            BURST: begin
                if (acc) beat_cnt_nx = beat_cnt + CNT_WIDTH'(1);
                // A full stall is neither an accept nor a release, so the burst just waits
                if ((acc && (beat_cnt == LAST_BEAT)) || !own_req) begin
                    state_nx      = IDLE;
                    last_owner_nx = owner;
                    beat_cnt_nx   = '0;
                end
            end
        endcase
    end

    assign bus.gnt      = gnt;
    assign bus.wr_en    = acc;
    assign bus.wr_data  = wr_data;
    assign bus.busy     = (state == BURST);
    assign bus.owner_id = owner;

`ifdef FIFO_ARB_STALL_CNT_EN
    // Owner has data but the FIFO is full; saturates instead of wrapping
    always_ff @(posedge clk_A or posedge rst_A) begin
        if (rst_A) begin
            stall_cnt <= '0;
        end else if ((state == BURST) && own_req && bus.full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    // No stall counter in this build.
`endif

endmodule
